// File: rtl/dice_pkg.sv
// ============================================================================
// Module   : dice_pkg
// Brief    : Shared state encoding, 7-segment face patterns and decoder for
//            the dice roll display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dice_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROLL  = 2'd1,
        BLINK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high; count value v shows face v+1.
    localparam logic [6:0] SEG_ONE   = 7'b0000110;
    localparam logic [6:0] SEG_TWO   = 7'b1011011;
    localparam logic [6:0] SEG_THREE = 7'b1001111;
    localparam logic [6:0] SEG_FOUR  = 7'b1100110;
    localparam logic [6:0] SEG_FIVE  = 7'b1101101;
    localparam logic [6:0] SEG_SIX   = 7'b1111101;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [2:0] FACE_NONE = 3'd0;

    function automatic logic [6:0] seg_decode(input logic [2:0] v);
        logic [6:0] r;
        case (v)
            3'd0:    r = SEG_ONE;
            3'd1:    r = SEG_TWO;
            3'd2:    r = SEG_THREE;
            3'd3:    r = SEG_FOUR;
            3'd4:    r = SEG_FIVE;
            3'd5:    r = SEG_SIX;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer plus counter debouncer for a raw button,
//            with one-cycle rise/fall pulses aligned to the debounced change.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic db_btn,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            // Any sample that agrees with the debounced level restarts the count.
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt  <= '0;
                r_db   <= r_sync2;
                r_rise <= r_sync2;
                r_fall <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db_btn = r_db;
    assign rise   = r_rise;
    assign fall   = r_fall;

endmodule

`default_nettype wire

// File: rtl/dice_roll_display.sv
// ============================================================================
// Module   : dice_roll_display
// Brief    : Button-driven die: shows the live mod-6 count while held, captures
//            on release, blinks the result, then holds it on a 7-segment digit.
//            Optional macro DICE_ROLL_COUNT_EN adds a saturating roll counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_roll_display
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_HALF      = 4,
    parameter int BLINK_HALVES    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] count_in,
    input  logic       btn_in,
    output logic [6:0] seg,
    output logic [2:0] face,
    output logic       face_vld,
    output logic       roll_done
`ifdef DICE_ROLL_COUNT_EN
    ,
    output logic [3:0] rolls
`endif
);

    localparam int                  HALF_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int                  HALVES_W    = $clog2(BLINK_HALVES + 1);
    localparam logic [HALF_W-1:0]   HALF_LAST   = HALF_W'(BLINK_HALF - 1);
    localparam logic [HALVES_W-1:0] HALVES_LAST = HALVES_W'(BLINK_HALVES - 1);

    logic w_db_btn;
    logic w_rise;
    logic w_fall;
    logic w_unused_db;

    state_t              r_state;
    logic [6:0]          r_seg;
    logic [2:0]          r_face;
    logic [2:0]          r_result;
    logic                r_face_vld;
    logic                r_roll_done;
    logic [HALF_W-1:0]   r_half_cnt;
    logic [HALVES_W-1:0] r_halves;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_in),
        .db_btn (w_db_btn),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // The FSM is driven purely by the edge pulses; the level is not needed.
    assign w_unused_db = w_db_btn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_seg       <= SEG_BLANK;
            r_face      <= FACE_NONE;
            r_result    <= 3'd0;
            r_face_vld  <= 1'b0;
            r_roll_done <= 1'b0;
            r_half_cnt  <= '0;
            r_halves    <= '0;
        end else begin
            r_roll_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_seg <= SEG_BLANK;
                    if (w_rise) begin
                        r_state <= ROLL;
                    end
                end
                ROLL: begin
                    r_seg <= seg_decode(count_in);
                    if (w_fall) begin
                        if (count_in <= 3'd5) begin
                            r_result   <= count_in;
                            r_face     <= 3'(count_in + 3'd1);
                            r_half_cnt <= '0;
                            r_halves   <= '0;
                            r_state    <= BLINK;
                        end else begin
                            r_face  <= FACE_NONE;
                            r_state <= IDLE;
                        end
                    end
                end
                BLINK: begin
                    // Even half-periods show the face, odd ones are blank.
                    r_seg <= r_halves[0] ? SEG_BLANK : seg_decode(r_result);
                    if (w_rise) begin
                        r_state <= ROLL;
                    end else if (r_half_cnt == HALF_LAST) begin
                        r_half_cnt <= '0;
                        if (r_halves == HALVES_LAST) begin
                            r_state     <= HOLD;
                            r_roll_done <= 1'b1;
                            r_face_vld  <= 1'b1;
                        end else begin
                            r_halves <= r_halves + 1'b1;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    r_seg <= seg_decode(r_result);
                    if (w_rise) begin
                        r_state    <= ROLL;
                        r_face_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign seg       = r_seg;
    assign face      = r_face;
    assign face_vld  = r_face_vld;
    assign roll_done = r_roll_done;

`ifdef DICE_ROLL_COUNT_EN
    logic [3:0] r_rolls;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rolls <= 4'd0;
        end else if (r_roll_done && (r_rolls != 4'd15)) begin
            r_rolls <= r_rolls + 4'd1;
        end
    end

    assign rolls = r_rolls;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_display.sv
// ============================================================================
// Module   : tb_dice_roll_display
// Brief    : Directed self-checking bench for dice_roll_display (default
//            parameters); DICE_ROLL_COUNT_EN enables the roll counter checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dice_roll_display;
    import dice_pkg::*;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_in   = 1'b0;
    logic [2:0] count_in = 3'd0;
    logic [6:0] seg;
    logic [2:0] face;
    logic       face_vld;
    logic       roll_done;
`ifdef DICE_ROLL_COUNT_EN
    logic [3:0] rolls;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cnt = 0;
    int done_cnt = 0;
    int k;

    // Hand-computed patterns for count values 0..6 (6 is blank).
    logic [6:0] exp_dec [0:6] = '{7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101,
                                  7'b0000000};

    always #5 clk = ~clk;

    dice_roll_display dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_in  (count_in),
        .btn_in    (btn_in),
        .seg       (seg),
        .face      (face),
        .face_vld  (face_vld),
        .roll_done (roll_done)
`ifdef DICE_ROLL_COUNT_EN
        ,
        .rolls     (rolls)
`endif
    );

    always @(posedge clk) begin
        if (dut.u_debounce.rise) rise_cnt++;
        if (roll_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int max, output int n);
        n = 0;
        while (!dut.u_debounce.rise && n < max) begin
            tick();
            n++;
        end
        check("rise_seen", 32'(dut.u_debounce.rise), 32'd1);
    endtask

    task automatic wait_fall(input int max, output int n);
        n = 0;
        while (!dut.u_debounce.fall && n < max) begin
            tick();
            n++;
        end
        check("fall_seen", 32'(dut.u_debounce.fall), 32'd1);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!roll_done && n < max) begin
            tick();
            n++;
        end
        check("done_seen", 32'(roll_done), 32'd1);
    endtask

    task automatic full_roll(input logic [2:0] v);
        int n;
        btn_in = 1'b1;
        wait_rise(40, n);
        tick();
        count_in = v;
        btn_in   = 1'b0;
        wait_fall(40, n);
        wait_done(40);
        tick();
    endtask

    initial begin
        // Reset with the button held high.
        rst_n  = 1'b0;
        btn_in = 1'b1;
        repeat (3) tick();
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_face", 32'(face), 32'd0);
        check("rst_face_vld", 32'(face_vld), 32'd0);
        check("rst_roll_done", 32'(roll_done), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
`ifdef DICE_ROLL_COUNT_EN
        check("rst_rolls", 32'(rolls), 32'd0);
`endif
        rst_n  = 1'b1;
        btn_in = 1'b0;
        repeat (20) tick();
        check("post_rst_no_rise", 32'(rise_cnt), 32'd0);

        // Bounce then settle high.
        for (int i = 0; i < 42; i++) begin
            btn_in = ((i / 3) % 2 == 0);
            tick();
        end
        check("bounce_no_rise", 32'(rise_cnt), 32'd0);
        btn_in = 1'b1;
        wait_rise(40, k);
        check("rise_latency", 32'(k), 32'd18);
        tick();
        check("bounce_state_roll", 32'(dut.r_state), 32'(ROLL));
        repeat (3) tick();
        check("bounce_one_rise", 32'(rise_cnt), 32'd1);

        // Live roll: seg registers dec(count_in) one cycle later.
        for (int v = 0; v < 7; v++) begin
            count_in = 3'(v);
            tick();
            check("live_seg", 32'(seg), 32'(exp_dec[v]));
            check("live_face_vld", 32'(face_vld), 32'd0);
        end

        // Capture count 3 -> face 4, blink, hold.
        count_in = 3'd3;
        btn_in   = 1'b0;
        done_cnt = 0;
        wait_fall(40, k);
        check("fall_latency", 32'(k), 32'd18);
        tick();
        check("cap_face", 32'(face), 32'd4);
        check("cap_state", 32'(dut.r_state), 32'(BLINK));
        count_in = 3'd5;
        for (int j = 1; j <= 24; j++) begin
            tick();
            check("blink_seg", 32'(seg), (((j - 1) / 4) % 2 == 0) ? 32'h66 : 32'h0);
            check("blink_done", 32'(roll_done), (j == 24) ? 32'd1 : 32'd0);
        end
        tick();
        check("hold_seg", 32'(seg), 32'h66);
        check("hold_face_vld", 32'(face_vld), 32'd1);
        check("hold_done_low", 32'(roll_done), 32'd0);
        check("hold_face", 32'(face), 32'd4);
        check("hold_done_cnt", 32'(done_cnt), 32'd1);

        // Press from HOLD, capture 1, then abort mid-blink.
        btn_in = 1'b1;
        wait_rise(40, k);
        tick();
        check("rehold_state", 32'(dut.r_state), 32'(ROLL));
        check("rehold_face_vld", 32'(face_vld), 32'd0);
        check("rehold_face_kept", 32'(face), 32'd4);
        count_in = 3'd1;
        btn_in   = 1'b0;
        wait_fall(40, k);
        tick();
        check("cap2_face", 32'(face), 32'd2);
        done_cnt = 0;
        btn_in   = 1'b1;
        wait_rise(40, k);
        tick();
        check("abort_state", 32'(dut.r_state), 32'(ROLL));
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_face_kept", 32'(face), 32'd2);

        // Illegal capture value 7.
        count_in = 3'd7;
        btn_in   = 1'b0;
        wait_fall(40, k);
        tick();
        check("illegal_state", 32'(dut.r_state), 32'(IDLE));
        check("illegal_face", 32'(face), 32'd0);
        tick();
        check("illegal_seg", 32'(seg), 32'd0);
        check("illegal_no_done", 32'(done_cnt), 32'd0);

        // Reset during ROLL.
        btn_in = 1'b1;
        wait_rise(40, k);
        tick();
        count_in = 3'd2;
        tick();
        check("pre_rst_seg", 32'(seg), 32'h4f);
        rst_n = 1'b0;
        tick();
        check("midrst_state", 32'(dut.r_state), 32'(IDLE));
        check("midrst_seg", 32'(seg), 32'd0);
        rst_n  = 1'b1;
        btn_in = 1'b0;
        repeat (3) tick();

        // Complete roll at the top boundary: count 5 -> face 6.
        full_roll(3'd5);
        check("roll5_face", 32'(face), 32'd6);
        check("roll5_seg", 32'(seg), 32'h7d);
        check("roll5_face_vld", 32'(face_vld), 32'd1);
`ifdef DICE_ROLL_COUNT_EN
        check("rolls_one", 32'(rolls), 32'd1);
        for (int r = 0; r < 16; r++) full_roll(3'(r % 6));
        check("rolls_sat", 32'(rolls), 32'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
